// File: rtl/sseg_scan.sv
// sseg_scan -- time-multiplexed driver for an 8-digit common-anode
// seven-segment display.
//
// Segment data is double-buffered: a load strobe captures seg_in/en_in into
// a shadow buffer, and the shadow is copied into the active buffer only at
// the frame boundary (last cycle of digit 7). This means a frame is never
// shown half-updated. Each digit slot lasts CLK_DIV cycles. The first BLANK
// cycles of each slot keep every anode off to suppress ghosting.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   seg_in  64-bit segment patterns, byte g -> digit g
//           (bit7=dp, bit6=a ... bit0=g, 1 = lit)
//   en_in   digit enable mask, bit g = 0 blanks digit g
//   load    single-cycle strobe capturing seg_in/en_in
//   pend    high while a captured frame waits for the frame boundary
//   an      anode drives (registered, polarity per ACTIVE_LOW)
//   cat     cathode drives (registered, polarity per ACTIVE_LOW)
//   dig     index of the digit currently being scanned
//   frame   one-cycle pulse the cycle after each frame boundary
module sseg_scan #(
    parameter int CLK_DIV    = 100000,
    parameter int BLANK      = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] seg_in,
    input  logic [7:0]  en_in,
    input  logic        load,
    output logic        pend,
    output logic [7:0]  an,
    output logic [7:0]  cat,
    output logic [2:0]  dig,
    output logic        frame
);

    localparam int         DIV_W = $clog2(CLK_DIV);
    localparam logic [7:0] OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       dig_q, dig_d;
    logic [63:0]      pend_seg_q, pend_seg_d;
    logic [7:0]       pend_en_q, pend_en_d;
    logic [63:0]      act_seg_q, act_seg_d;
    logic [7:0]       act_en_q, act_en_d;
    logic             pend_q, pend_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       cat_q, cat_d;
    logic             frame_q, frame_d;

    logic             slot_end;
    logic             boundary;
    logic             lit;
    logic [7:0]       an_raw;
    logic [7:0]       cat_raw;

    always_comb begin
        slot_end   = (div_q == DIV_W'(CLK_DIV - 1));
        boundary   = slot_end && (dig_q == 3'd7);

        div_d      = slot_end ? '0 : div_q + 1'b1;
        dig_d      = slot_end ? dig_q + 3'd1 : dig_q;

        pend_seg_d = pend_seg_q;
        pend_en_d  = pend_en_q;
        act_seg_d  = act_seg_q;
        act_en_d   = act_en_q;
        pend_d     = pend_q;

        if (boundary) begin
            // A load landing on the boundary itself bypasses the shadow and
            // supersedes any older pending frame.
            if (load) begin
                act_seg_d = seg_in;
                act_en_d  = en_in;
            end else if (pend_q) begin
                act_seg_d = pend_seg_q;
                act_en_d  = pend_en_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_seg_d = seg_in;
            pend_en_d  = en_in;
            pend_d     = 1'b1;
        end

        // Drive is derived from the current scan position and registered,
        // so the pins lag dig/div_cnt by one cycle.
        lit     = (div_q >= DIV_W'(BLANK)) && act_en_q[dig_q];
        an_raw  = lit ? (8'h01 << dig_q) : 8'h00;
        cat_raw = lit ? act_seg_q[{dig_q, 3'b000} +: 8] : 8'h00;
        an_d    = ACTIVE_LOW ? ~an_raw  : an_raw;
        cat_d   = ACTIVE_LOW ? ~cat_raw : cat_raw;

        frame_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            dig_q      <= 3'd0;
            pend_seg_q <= 64'd0;
            pend_en_q  <= 8'd0;
            act_seg_q  <= 64'd0;
            act_en_q   <= 8'd0;
            pend_q     <= 1'b0;
            an_q       <= OFF;
            cat_q      <= OFF;
            frame_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            dig_q      <= dig_d;
            pend_seg_q <= pend_seg_d;
            pend_en_q  <= pend_en_d;
            act_seg_q  <= act_seg_d;
            act_en_q   <= act_en_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
            frame_q    <= frame_d;
        end
    end

    assign pend  = pend_q;
    assign an    = an_q;
    assign cat   = cat_q;
    assign dig   = dig_q;
    assign frame = frame_q;

endmodule

// File: doc/sseg_scan.md
# sseg_scan

Time-multiplexed scanner that drives an 8-digit common-anode seven-segment display from the 64-bit segment vector produced by the display decoder. It sits between the decoder and the board pins. It double-buffers the segment data so a new frame is never shown half-updated, and it scans one digit per slot. Each slot starts with a programmable anti-ghosting blank interval.

## Interface
Parameters:
- CLK_DIV, 100000: clock cycles per digit slot; legal range ≥ 2.
- BLANK, 1000: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK < CLK_DIV.
- ACTIVE_LOW, 1: 1 means `an` and `cat` are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_in  in  64  segment patterns; byte g drives digit g.
  - Within each byte: bit7=dp, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; 1 = lit.
- en_in  in  8  digit enable mask; bit g=0 blanks digit g.
- load  in  1  single-cycle strobe that captures seg_in and en_in.
- pend  out  1  1 while a captured frame is waiting for the frame boundary.
- an  out  8  anode drives; bit g selects digit g.
- cat  out  8  cathode drives in the seg_in byte bit order, with polarity applied.
- dig  out  3  index of the digit currently being scanned.
- frame  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- Registers:
  - div_cnt counts 0..CLK_DIV-1.
  - dig counts 0..7.
  - pend_seg/pend_en form the shadow buffer.
  - act_seg/act_en form the active buffer.
  - pend flag.
  - an, cat, frame are registered outputs.
- Counting:
  - div_cnt increments every cycle.
  - At CLK_DIV-1, div_cnt returns to 0 and dig increments mod 8.
- Boundary: the cycle in which dig=7 and div_cnt=CLK_DIV-1.
- Load, when not in a boundary cycle:
  - pend_seg←seg_in, pend_en←en_in, pend←1.
  - Repeated loads before the boundary overwrite the shadow; the last load wins.
- Boundary without load:
  - If pend=1: act←pend buffers and pend←0.
  - If pend=0: active buffers are unchanged.
- Boundary with simultaneous load:
  - act_seg←seg_in, act_en←en_in directly, and pend←0.
  - The load wins over any older pending frame.
- Drive, computed from the current dig/div_cnt and registered:
  - Anode g is asserted iff g=dig, div_cnt≥BLANK, and act_en[dig]=1. All other anodes are deasserted.
  - cat = act_seg[dig*8+:8] whenever the digit is lit. Otherwise cat = all segments off.
  - Polarity: ACTIVE_LOW=1 inverts both an and cat (asserted = 0).
- frame: registered; high for exactly one cycle, the cycle after each boundary.
- Reset (asynchronous), applied immediately:
  - div_cnt=0, dig=0, pend=0, frame=0.
  - pend and act buffers cleared.
  - an and cat at the all-off level (8'hFF when ACTIVE_LOW=1, 8'h00 when ACTIVE_LOW=0).
  - After reset the display stays dark until the first frame is committed.
- Reset mid-slot or mid-frame:
  - Any pending frame is discarded.
  - Scan restarts at digit 0, div_cnt 0 on the first edge after deassertion.

## Timing
- an/cat lag (dig, div_cnt) by 1 cycle.
- The slot for digit d is visible on the pins for exactly CLK_DIV cycles:
  - first BLANK cycles: blank;
  - remaining CLK_DIV-BLANK cycles: lit.
- Frame period is 8·CLK_DIV cycles.
- Load-to-display latency:
  - A load is shown starting at the next digit-0 slot.
  - The first lit pins appear BLANK+1 cycles after the boundary edge.
  - Worst case is 8·CLK_DIV+BLANK+1 cycles.
- BLANK=0: no blank interval; adjacent slots switch anodes on consecutive cycles.
- A load in the boundary cycle itself appears in the immediately following frame.
- pend:
  - rises the cycle after a non-boundary load;
  - falls the cycle after the boundary.

## Test plan
Every scenario uses CLK_DIV=4, BLANK=1, ACTIVE_LOW=1.
- Reset state:
  - Stimulus: hold rst high, release, run one frame with no load.
  - Response: an=8'hFF and cat=8'hFF throughout; dig steps 0→7 every 4 cycles; frame pulses once per 32 cycles.
- Digit scan after commit:
  - Stimulus: load seg_in=64'h7B7F705F5B33797E with en_in=8'hFF.
  - Response, from the first slot after the boundary:
    - slot 0: an=8'hFE, cat=8'h81;
    - slot 1: an=8'hFD, cat=8'h86;
    - … through slot 7: an=8'h7F, cat=8'h84.
  - In every slot, the first visible cycle has an=8'hFF and cat=8'hFF.
- Tear-free update:
  - Stimulus: load frame A, let it commit, then during slot 3 load frame B.
  - Response: pend=1 and slots 3..7 still show A. At the wrap, pend→0 and slot 0 shows B.
- Simultaneous load at boundary:
  - Stimulus: load C, then load D in the boundary cycle.
  - Response: the next frame shows D; C is never displayed; pend=0.
- Enable mask:
  - Stimulus: en_in=8'b1010_1010.
  - Response: slots 0, 2, 4, 6 keep an=8'hFF and cat=8'hFF for the full slot; odd slots are lit; slot timing is unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during slot 5 with a pending frame.
  - Response: an and cat go to 8'hFF immediately, pend=0, and the display stays dark after release until a new load commits.
